// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag types and flag bit positions for the pipelined ALU
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_SHL    = 3'b101,
    OP_SRA    = 3'b110,
    OP_PASS_A = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational signed ALU with Z/N/C/V flags
// ALU_PIPE_SAT_EN selects saturating ADD/SUB instead of wrap-around.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] W_MAX_AMT = WIDTH'(WIDTH);
  localparam logic [SHW:0]     W_CLAMP   = (SHW+1)'(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_sra;
  logic [SHW:0]     w_amt;
  logic             w_big;
  logic             w_add_v;
  logic             w_sub_v;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  alu_op_e          w_op;

  assign w_op    = alu_op_e'(op);
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_add_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  // One spare bit on each shift catches the last bit shifted out; amounts past WIDTH clamp to WIDTH.
  assign w_big = (b > W_MAX_AMT);
  assign w_amt = w_big ? W_CLAMP : b[SHW:0];
  assign w_shl = {1'b0, a} << w_amt;
  assign w_sra = $signed({a, 1'b0}) >>> w_amt;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_v;
      end
      OP_AND:    w_res = a & b;
      OP_OR:     w_res = a | b;
      OP_XOR:    w_res = a ^ b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_big ? 1'b0 : w_shl[WIDTH];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_big ? 1'b0 : w_sra[0];
      end
      default:   w_res = a;
    endcase
`ifdef ALU_PIPE_SAT_EN
    // Overflow direction follows the sign of a for both ADD and SUB.
    if (((w_op == OP_ADD) || (w_op == OP_SUB)) && w_v) begin
      w_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign result        = w_res;
  assign flags[FLAG_Z] = (w_res == '0);
  assign flags[FLAG_N] = w_res[WIDTH-1];
  assign flags[FLAG_C] = w_c;
  assign flags[FLAG_V] = w_v;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready pipelined ALU wrapper around alu_core
// ALU_PIPE_SAT_EN (handled in alu_core) enables saturating ADD/SUB.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             r_s1_valid;
  logic             r_s2_valid;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             w_en1;
  logic             w_en2;
  logic [WIDTH-1:0] w_core_result;
  logic [3:0]       w_core_flags;

  // Ready ripples back from out_ready so a full pipe can advance and refill on the same edge.
  assign w_en2    = !r_s2_valid || out_ready;
  assign w_en1    = !r_s1_valid || w_en2;
  assign in_ready = w_en1;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .result (w_core_result),
    .flags  (w_core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_flags    <= '0;
    end else begin
      if (w_en1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_op <= alu_op_e'(op);
          r_a  <= a;
          r_b  <= b;
        end
      end
      if (w_en2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result <= w_core_result;
          r_flags  <= w_core_flags;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [11:0] sb_q[$];
  int          acc_cycles[$];
  int          out_cycles[$];
  logic        got;
  logic [7:0]  last_res;
  logic [3:0]  last_flags;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_res;
  logic [3:0]  stall_flags;
  logic        t_acc;
  logic        t_ir;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Reference: exact integer arithmetic, then range/saturation rules; returns {result, Z, N, C, V}.
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    int   sa, sb, ua, ub, r;
    logic c, v, z, n;
    logic [7:0] r8;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = int'(av);
    ub = int'(bv);
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin r = sa + sb; c = (ua + ub) > 255; v = (r > 127) || (r < -128); end
      3'd1: begin r = sa - sb; c = ua < ub;         v = (r > 127) || (r < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r = (ub >= 8) ? 0 : (ua << ub);
        if (ub >= 1 && ub <= 8) c = ((ua >> (8 - ub)) & 1) != 0;
      end
      3'd6: begin
        r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
        if (ub >= 1 && ub <= 8) c = ((ua >> (ub - 1)) & 1) != 0;
      end
      default: r = ua;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if (v) r = (r > 0) ? 127 : -128;
`endif
    r8 = r[7:0];
    z = (r8 == 8'd0);
    n = r8[7];
    return {r8, z, n, c, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, score the output side, advance past the next edge.
  task automatic cycle(input logic iv, input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ordy, input logic rr, output logic acc, output logic ir);
    logic [11:0] e;
    in_valid  = iv;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    rst       = rr;
    #1;
    ir  = in_ready;
    acc = iv && in_ready && !rr;
    if (stall_prev) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'(result), 32'(stall_res));
      check("stall_flags", 32'(flags), 32'(stall_flags));
    end
    stall_prev  = out_valid && !ordy && !rr;
    stall_res   = result;
    stall_flags = flags;
    if (acc) begin
      sb_q.push_back(model(o, aa, bb));
      acc_cycles.push_back(cyc);
    end
    if (out_valid && ordy && !rr) begin
      total++;
      assert (sb_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_out: observed result=%0h with empty scoreboard, expected no out_valid", result);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("result", 32'(result), 32'(e[11:4]));
        check("flags", 32'(flags), 32'(e[3:0]));
        got        = 1'b1;
        last_res   = result;
        last_flags = flags;
        out_cycles.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_one(input string tag, input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [7:0] er, input logic [3:0] ef);
    got = 1'b0;
    cycle(1'b1, o, aa, bb, 1'b1, 1'b0, t_acc, t_ir);
    for (int i = 0; i < 6 && !got; i++) cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b0, t_acc, t_ir);
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_res"}, 32'(last_res), 32'(er));
    check({tag, "_flags"}, 32'(last_flags), 32'(ef));
  endtask

  initial begin
    int          idx;
    logic [2:0]  ro;
    logic [7:0]  ra, rb;
    logic [7:0]  bp_a[4];
    logic [7:0]  bp_b[4];

    cycle(1'b1, 3'd0, 8'd1, 8'd1, 1'b1, 1'b1, t_acc, t_ir);
    cycle(1'b1, 3'd0, 8'd1, 8'd1, 1'b1, 1'b1, t_acc, t_ir);
    rst = 1'b0;
    #0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    run_one("add_127", 3'd0, 8'd100, 8'd27, 8'd127, 4'b0000);
`ifdef ALU_PIPE_SAT_EN
    run_one("add_ovf", 3'd0, 8'd100, 8'd28, 8'h7F, 4'b0001);
`else
    run_one("add_ovf", 3'd0, 8'd100, 8'd28, 8'h80, 4'b0101);
`endif
    run_one("sub_zero", 3'd1, 8'd5, 8'd5, 8'h00, 4'b1000);
    run_one("sub_borrow", 3'd1, 8'd3, 8'd5, 8'hFE, 4'b0110);
    run_one("sra_big", 3'd6, 8'h80, 8'd10, 8'hFF, 4'b0100);
    run_one("shl_1", 3'd5, 8'h81, 8'd1, 8'h02, 4'b0010);
    run_one("shl_8", 3'd5, 8'h80, 8'd8, 8'h00, 4'b1000);
    run_one("pass_a", 3'd7, 8'h9C, 8'h11, 8'h9C, 4'b0100);

    acc_cycles.delete();
    out_cycles.delete();
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = (ro >= 3'd5) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      cycle(1'b1, ro, ra, rb, 1'b1, 1'b0, t_acc, t_ir);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b0, t_acc, t_ir);
    check("b2b_accepts", 32'(acc_cycles.size()), 32'd16);
    check("b2b_outputs", 32'(out_cycles.size()), 32'd16);
    if (acc_cycles.size() > 0 && out_cycles.size() > 0)
      check("b2b_latency", 32'(out_cycles[0]), 32'(acc_cycles[0] + 2));
    for (int i = 1; i < out_cycles.size(); i++)
      check("b2b_throughput", 32'(out_cycles[i]), 32'(out_cycles[0] + i));

    bp_a = '{8'd10, 8'd20, 8'd30, 8'd40};
    bp_b = '{8'd1, 8'd2, 8'd3, 8'd4};
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(idx < 4, 3'd0, bp_a[idx % 4], bp_b[idx % 4], c >= 3, 1'b0, t_acc, t_ir);
      if (c == 1) check("bp_ready_c1", 32'(t_ir), 32'd1);
      if (c == 2) check("bp_ready_low", 32'(t_ir), 32'd0);
      if (c == 3) check("bp_ready_rise", 32'(t_ir), 32'd1);
      if (t_acc) idx++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b0, t_acc, t_ir);
    check("bp_all_accepted", 32'(idx), 32'd4);
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = (ro >= 3'd5) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      cycle(($urandom % 4) != 0, ro, ra, rb, ($urandom % 3) != 0, 1'b0, t_acc, t_ir);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b0, t_acc, t_ir);
    check("rand_drained", 32'(sb_q.size()), 32'd0);

    cycle(1'b1, 3'd0, 8'd1, 8'd2, 1'b0, 1'b0, t_acc, t_ir);
    cycle(1'b1, 3'd0, 8'd3, 8'd4, 1'b0, 1'b0, t_acc, t_ir);
    cycle(1'b1, 3'd0, 8'd5, 8'd6, 1'b1, 1'b1, t_acc, t_ir);
    sb_q.delete();
    in_valid  = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    #0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b0, t_acc, t_ir);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
